// File: rtl/video_signal_generator.sv
// Raster timing master: nested sx/sy modulo counters plus a frame counter, with sync/de/nf decoded from position.
// Latency: all decodes are combinational from the position registers. Backpressure: none, it free-runs and consumers hold it in i_reset.
// Build option VIDEO_SIGNAL_GENERATOR_NEG_SYNC_EN makes o_hsync/o_vsync active-low.
module video_signal_generator #(
    parameter int ACTIVE_H_PIXELS = 1280,
    parameter int H_FRONT_PORCH   = 110,
    parameter int H_SYNCH_WIDTH   = 40,
    parameter int H_BACK_PORCH    = 220,
    parameter int ACTIVE_LINES    = 720,
    parameter int V_FRONT_PORCH   = 5,
    parameter int V_SYNCH_WIDTH   = 5,
    parameter int V_BACK_PORCH    = 20,
    parameter int FPS             = 60,
    localparam int H_TOTAL = ACTIVE_H_PIXELS + H_FRONT_PORCH + H_SYNCH_WIDTH + H_BACK_PORCH,
    localparam int V_TOTAL = ACTIVE_LINES + V_FRONT_PORCH + V_SYNCH_WIDTH + V_BACK_PORCH,
    localparam int SXW     = $clog2(H_TOTAL),
    localparam int SYW     = $clog2(V_TOTAL),
    localparam int FCW     = $clog2(FPS)
) (
    input  logic           i_clk_pxl,
    input  logic           i_reset,
    output logic [SXW-1:0] o_sx,
    output logic [SYW-1:0] o_sy,
    output logic           o_hsync,
    output logic           o_vsync,
    output logic           o_de,
    output logic           o_nf,
    output logic [FCW-1:0] o_fc
);

    localparam logic [SXW-1:0] SX_LAST  = SXW'(H_TOTAL - 1);
    localparam logic [SXW-1:0] H_ACT    = SXW'(ACTIVE_H_PIXELS);
    localparam logic [SXW-1:0] HS_START = SXW'(ACTIVE_H_PIXELS + H_FRONT_PORCH);
    localparam logic [SXW-1:0] HS_END   = SXW'(ACTIVE_H_PIXELS + H_FRONT_PORCH + H_SYNCH_WIDTH - 1);
    localparam logic [SYW-1:0] SY_LAST  = SYW'(V_TOTAL - 1);
    localparam logic [SYW-1:0] V_ACT    = SYW'(ACTIVE_LINES);
    localparam logic [SYW-1:0] VS_START = SYW'(ACTIVE_LINES + V_FRONT_PORCH);
    localparam logic [SYW-1:0] VS_END   = SYW'(ACTIVE_LINES + V_FRONT_PORCH + V_SYNCH_WIDTH - 1);
    localparam logic [FCW-1:0] FC_LAST  = FCW'(FPS - 1);

    logic [SXW-1:0] sx_q, sx_d;
    logic [SYW-1:0] sy_q, sy_d;
    logic [FCW-1:0] fc_q, fc_d;
    logic           hs_act;
    logic           vs_act;

    always_comb begin
        sx_d = sx_q;
        sy_d = sy_q;
        fc_d = fc_q;
        if (sx_q != SX_LAST) begin
            sx_d = sx_q + 1'b1;
        end else begin
            sx_d = '0;
            if (sy_q != SY_LAST) begin
                sy_d = sy_q + 1'b1;
            end else begin
                sy_d = '0;
                fc_d = (fc_q == FC_LAST) ? '0 : fc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk_pxl) begin
        if (i_reset) begin
            sx_q <= '0;
            sy_q <= '0;
            fc_q <= '0;
        end else begin
            sx_q <= sx_d;
            sy_q <= sy_d;
            fc_q <= fc_d;
        end
    end

    // Decodes come straight off the registers so every output describes the same pixel.
    assign hs_act = (sx_q >= HS_START) && (sx_q <= HS_END);
    assign vs_act = (sy_q >= VS_START) && (sy_q <= VS_END);

`ifdef VIDEO_SIGNAL_GENERATOR_NEG_SYNC_EN
    assign o_hsync = ~hs_act;
    assign o_vsync = ~vs_act;
`else
    assign o_hsync = hs_act;
    assign o_vsync = vs_act;
`endif

    assign o_de = (sx_q < H_ACT) && (sy_q < V_ACT);
    assign o_nf = (sx_q == '0) && (sy_q == '0);
    assign o_sx = sx_q;
    assign o_sy = sy_q;
    assign o_fc = fc_q;

endmodule

// File: tb/tb_video_signal_generator.sv
// Bench for video_signal_generator: a default-timing instance for line-level behaviour and a
// shrunken-timing instance (28x19 raster, 532-cycle frames) for vertical, frame and fc wrap behaviour.
module tb_video_signal_generator;

`ifdef VIDEO_SIGNAL_GENERATOR_NEG_SYNC_EN
    localparam logic NEG = 1'b1;
`else
    localparam logic NEG = 1'b0;
`endif

    // Shrunken timing: H 16+4+3+5=28, V 10+2+3+4=19
    localparam int SH = 28;
    localparam int SV = 19;
    localparam int SF = SH * SV;

    logic        clk;
    logic        rst;
    logic [10:0] d_sx;
    logic [9:0]  d_sy;
    logic        d_hs, d_vs, d_de, d_nf;
    logic [5:0]  d_fc;
    logic [4:0]  s_sx;
    logic [4:0]  s_sy;
    logic        s_hs, s_vs, s_de, s_nf;
    logic [5:0]  s_fc;

    int pass_cnt;
    int total_cnt;
    int t;

    video_signal_generator dut_def (
        .i_clk_pxl(clk), .i_reset(rst),
        .o_sx(d_sx), .o_sy(d_sy), .o_hsync(d_hs), .o_vsync(d_vs),
        .o_de(d_de), .o_nf(d_nf), .o_fc(d_fc)
    );

    video_signal_generator #(
        .ACTIVE_H_PIXELS(16), .H_FRONT_PORCH(4), .H_SYNCH_WIDTH(3), .H_BACK_PORCH(5),
        .ACTIVE_LINES(10), .V_FRONT_PORCH(2), .V_SYNCH_WIDTH(3), .V_BACK_PORCH(4),
        .FPS(60)
    ) dut_sm (
        .i_clk_pxl(clk), .i_reset(rst),
        .o_sx(s_sx), .o_sy(s_sy), .o_hsync(s_hs), .o_vsync(s_vs),
        .o_de(s_de), .o_nf(s_nf), .o_fc(s_fc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // t counts free-running edges since the last reset release; outputs are sampled on negedges.
    task automatic run_to(input int target);
        while (t < target) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic check_reset_state(input string tag);
        total_cnt++;
        if (d_sx !== 11'd0 || d_sy !== 10'd0 || d_fc !== 6'd0)
            $display("FAIL %s_pos got sx=%0d sy=%0d fc=%0d want 0/0/0", tag, d_sx, d_sy, d_fc);
        else pass_cnt++;
        total_cnt++;
        if (d_de !== 1'b1 || d_nf !== 1'b1)
            $display("FAIL %s_de_nf got de=%b nf=%b want 1/1", tag, d_de, d_nf);
        else pass_cnt++;
        total_cnt++;
        if (d_hs !== NEG || d_vs !== NEG)
            $display("FAIL %s_sync got hs=%b vs=%b want %b/%b", tag, d_hs, d_vs, NEG, NEG);
        else pass_cnt++;
        total_cnt++;
        if (s_sx !== 5'd0 || s_sy !== 5'd0 || s_fc !== 6'd0 || s_nf !== 1'b1)
            $display("FAIL %s_small got sx=%0d sy=%0d fc=%0d nf=%b want 0/0/0/1", tag, s_sx, s_sy, s_fc, s_nf);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_reset_state("por");
        end
        rst = 1'b0;
        t = 0;
        run_to(2 * 1650 + 1400);
        total_cnt++;
        if (d_sx !== 11'd1400 || d_sy !== 10'd2 || d_hs !== ~NEG)
            $display("FAIL pre_reset got sx=%0d sy=%0d hs=%b want 1400/2/%b", d_sx, d_sy, d_hs, ~NEG);
        else pass_cnt++;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_reset_state("mid_rst");
        end
        rst = 1'b0;
        t = 0;
        run_to(1);
        total_cnt++;
        if (d_sx !== 11'd1 || d_sy !== 10'd0 || d_nf !== 1'b0)
            $display("FAIL release got sx=%0d sy=%0d nf=%b want 1/0/0", d_sx, d_sy, d_nf);
        else pass_cnt++;
    endtask

    task automatic test_hsync();
        int hs_cnt;
        run_to(1389);
        total_cnt++;
        if (d_sx !== 11'd1389 || d_hs !== NEG)
            $display("FAIL hs_1389 got sx=%0d hs=%b want 1389/%b", d_sx, d_hs, NEG);
        else pass_cnt++;
        hs_cnt = 0;
        for (int x = 1390; x <= 1430; x++) begin
            run_to(x);
            if (d_hs === ~NEG) hs_cnt++;
            if (x == 1390 || x == 1429) begin
                total_cnt++;
                if (d_hs !== ~NEG)
                    $display("FAIL hs_edge_%0d got %b want %b", x, d_hs, ~NEG);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (d_sx !== 11'd1430 || d_hs !== NEG)
            $display("FAIL hs_1430 got sx=%0d hs=%b want 1430/%b", d_sx, d_hs, NEG);
        else pass_cnt++;
        total_cnt++;
        if (hs_cnt != 40)
            $display("FAIL hs_width got %0d want 40", hs_cnt);
        else pass_cnt++;
    endtask

    task automatic test_line_wrap();
        int de_err;
        run_to(10 * 1650 + 1279);
        total_cnt++;
        if (d_sx !== 11'd1279 || d_sy !== 10'd10 || d_de !== 1'b1)
            $display("FAIL de_1279 got sx=%0d sy=%0d de=%b want 1279/10/1", d_sx, d_sy, d_de);
        else pass_cnt++;
        de_err = 0;
        for (int x = 1280; x <= 1649; x++) begin
            run_to(10 * 1650 + x);
            if (d_de !== 1'b0) de_err++;
        end
        total_cnt++;
        if (d_sx !== 11'd1649 || d_sy !== 10'd10 || de_err != 0)
            $display("FAIL line_end got sx=%0d sy=%0d de_err=%0d want 1649/10/0", d_sx, d_sy, de_err);
        else pass_cnt++;
        run_to(11 * 1650);
        total_cnt++;
        if (d_sx !== 11'd0 || d_sy !== 10'd11 || d_de !== 1'b1 || d_fc !== 6'd0)
            $display("FAIL line_wrap got sx=%0d sy=%0d de=%b fc=%0d want 0/11/1/0", d_sx, d_sy, d_de, d_fc);
        else pass_cnt++;
    endtask

    // Sweeps one full small-raster frame against a position model.
    task automatic test_vertical();
        int base, ex, ey, pos_err, vs_err, hs_err, de_err, nf_cnt;
        logic exp_vs, exp_hs, exp_de;
        base = ((t / SF) + 1) * SF;
        pos_err = 0; vs_err = 0; hs_err = 0; de_err = 0; nf_cnt = 0;
        for (int k = 0; k < SF; k++) begin
            run_to(base + k);
            ex = k % SH;
            ey = k / SH;
            exp_vs = ((ey >= 12 && ey <= 14) ? 1'b1 : 1'b0) ^ NEG;
            exp_hs = ((ex >= 20 && ex <= 22) ? 1'b1 : 1'b0) ^ NEG;
            exp_de = (ex < 16 && ey < 10) ? 1'b1 : 1'b0;
            if (s_sx !== 5'(ex) || s_sy !== 5'(ey)) pos_err++;
            if (s_vs !== exp_vs) vs_err++;
            if (s_hs !== exp_hs) hs_err++;
            if (s_de !== exp_de) de_err++;
            if (s_nf === 1'b1) nf_cnt++;
        end
        total_cnt++;
        if (pos_err != 0) $display("FAIL sm_position got %0d bad pixels want 0", pos_err);
        else pass_cnt++;
        total_cnt++;
        if (vs_err != 0) $display("FAIL sm_vsync got %0d bad pixels want 0", vs_err);
        else pass_cnt++;
        total_cnt++;
        if (hs_err != 0) $display("FAIL sm_hsync got %0d bad pixels want 0", hs_err);
        else pass_cnt++;
        total_cnt++;
        if (de_err != 0) $display("FAIL sm_de got %0d bad pixels want 0", de_err);
        else pass_cnt++;
        total_cnt++;
        if (nf_cnt != 1) $display("FAIL sm_nf_per_frame got %0d want 1", nf_cnt);
        else pass_cnt++;
    endtask

    task automatic test_frame_wrap();
        int fend, f;
        fend = ((t / SF) + 2) * SF - 1;
        f = (fend / SF) % 60;
        run_to(fend);
        total_cnt++;
        if (s_sx !== 5'd27 || s_sy !== 5'd18 || s_fc !== 6'(f) || s_nf !== 1'b0)
            $display("FAIL frame_end got sx=%0d sy=%0d fc=%0d nf=%b want 27/18/%0d/0", s_sx, s_sy, s_fc, s_nf, f);
        else pass_cnt++;
        run_to(fend + 1);
        total_cnt++;
        if (s_sx !== 5'd0 || s_sy !== 5'd0 || s_nf !== 1'b1 || s_fc !== 6'(f + 1))
            $display("FAIL frame_wrap got sx=%0d sy=%0d nf=%b fc=%0d want 0/0/1/%0d", s_sx, s_sy, s_nf, s_fc, f + 1);
        else pass_cnt++;
        run_to(fend + 2);
        total_cnt++;
        if (s_nf !== 1'b0 || s_sx !== 5'd1)
            $display("FAIL nf_pulse got nf=%b sx=%0d want 0/1", s_nf, s_sx);
        else pass_cnt++;
    endtask

    task automatic test_fc_wrap();
        run_to(60 * SF - 1);
        total_cnt++;
        if (s_fc !== 6'd59 || s_sx !== 5'd27 || s_sy !== 5'd18)
            $display("FAIL fc_59 got fc=%0d sx=%0d sy=%0d want 59/27/18", s_fc, s_sx, s_sy);
        else pass_cnt++;
        run_to(60 * SF);
        total_cnt++;
        if (s_fc !== 6'd0 || s_nf !== 1'b1)
            $display("FAIL fc_wrap got fc=%0d nf=%b want 0/1", s_fc, s_nf);
        else pass_cnt++;
        total_cnt++;
        if (d_fc !== 6'd0)
            $display("FAIL def_fc_static got %0d want 0", d_fc);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        t = 0;
        rst = 1'b1;
        test_reset();
        test_hsync();
        test_line_wrap();
        test_vertical();
        test_frame_wrap();
        test_fc_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
